// File: rtl/pc_next_pkg.sv
// Shared encodings for the fetch-stage PC generator: FSM states and next-PC select.
package pc_next_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'b00;
    localparam state_t ST_RUN    = 2'b01;
    localparam state_t ST_HALTED = 2'b10;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR
    } pc_sel_e;

endpackage

// File: rtl/pc_target_adder.sv
// Unsigned PC base plus signed, optionally shifted offset; reports wrap out of PC_LENGTH bits.
module pc_target_adder #(
    parameter int PC_LENGTH     = 11,
    parameter int OFFSET_LENGTH = 16,
    parameter int OFFSET_SHIFT  = 0
) (
    input  logic [PC_LENGTH-1:0]     base_i,
    input  logic [OFFSET_LENGTH-1:0] offset_i,
    output logic [PC_LENGTH-1:0]     sum_o,
    output logic                     wrap_o
);

    localparam int W = PC_LENGTH + OFFSET_SHIFT;

    logic signed [W-1:0] off_ext;
    logic signed [W-1:0] off_sh;
    logic        [W:0]   sum;

    generate
        if (OFFSET_LENGTH >= W) begin : g_trunc
            assign off_ext = offset_i[W-1:0];
        end else begin : g_sext
            assign off_ext = {{(W-OFFSET_LENGTH){offset_i[OFFSET_LENGTH-1]}}, offset_i};
        end
    endgenerate

    assign off_sh = off_ext <<< OFFSET_SHIFT;

    // Any non-zero bit above PC_LENGTH means carry out or borrow below zero.
    assign sum    = {{(W+1-PC_LENGTH){1'b0}}, base_i} + {off_sh[W-1], off_sh};
    assign sum_o  = sum[PC_LENGTH-1:0];
    assign wrap_o = |sum[W:PC_LENGTH];

endmodule

// File: rtl/pc_next_unit.sv
// Registered fetch PC generator with IDLE/RUN/HALTED sequencing and a saturating fetch counter.
// Optional sticky wrap flag output under `define PC_WRAP_DETECT_EN.
module pc_next_unit
    import pc_next_pkg::*;
#(
    parameter int PC_LENGTH     = 11,
    parameter int OFFSET_LENGTH = 16,
    parameter int OFFSET_SHIFT  = 0,
    parameter int INC_STEP      = 1,
    parameter int RESET_PC      = 0,
    parameter int COUNT_LENGTH  = 32
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable,
    input  logic                     i_stall,
    input  logic                     i_halt,
    input  logic                     i_branch_taken,
    input  logic [OFFSET_LENGTH-1:0] i_branch_offset,
    input  logic                     i_jump,
    input  logic [PC_LENGTH-1:0]     i_jump_target,
    input  logic                     i_jump_reg,
    input  logic [PC_LENGTH-1:0]     i_reg_target,
    output logic [PC_LENGTH-1:0]     o_pc,
    output logic [PC_LENGTH-1:0]     o_pc_plus_step,
    output logic                     o_valid,
    output logic                     o_halted,
`ifdef PC_WRAP_DETECT_EN
    output logic                     o_wrap,
`endif
    output logic [COUNT_LENGTH-1:0]  o_fetch_count
);

    state_t                  state_q, state_d;
    pc_sel_e                 sel;
    logic [PC_LENGTH-1:0]    pc_q, pc_d;
    logic [COUNT_LENGTH-1:0] cnt_q, cnt_d;
    logic [PC_LENGTH:0]      seq_sum;
    logic [PC_LENGTH-1:0]    br_sum;
    logic                    br_wrap;

    always_ff @(posedge i_clock) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_enable) state_d = ST_RUN;
            ST_RUN:    if (i_halt)   state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_valid  = (state_q == ST_RUN);
        o_halted = (state_q == ST_HALTED);
        sel      = SEL_HOLD;
        if (state_q == ST_RUN && !i_halt && !i_stall) begin
            if      (i_jump_reg)     sel = SEL_JR;
            else if (i_jump)         sel = SEL_J;
            else if (i_branch_taken) sel = SEL_BR;
            else                     sel = SEL_SEQ;
        end
    end

    assign seq_sum        = {1'b0, pc_q} + (PC_LENGTH+1)'(INC_STEP);
    assign o_pc_plus_step = seq_sum[PC_LENGTH-1:0];

    pc_target_adder #(
        .PC_LENGTH     (PC_LENGTH),
        .OFFSET_LENGTH (OFFSET_LENGTH),
        .OFFSET_SHIFT  (OFFSET_SHIFT)
    ) u_br_adder (
        .base_i   (o_pc_plus_step),
        .offset_i (i_branch_offset),
        .sum_o    (br_sum),
        .wrap_o   (br_wrap)
    );

    always_comb begin
        pc_d = pc_q;
        case (sel)
            SEL_SEQ: pc_d = o_pc_plus_step;
            SEL_BR:  pc_d = br_sum;
            SEL_J:   pc_d = i_jump_target;
            SEL_JR:  pc_d = i_reg_target;
            default: pc_d = pc_q;
        endcase
        cnt_d = cnt_q;
        if (sel != SEL_HOLD && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            pc_q  <= PC_LENGTH'(RESET_PC);
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

`ifdef PC_WRAP_DETECT_EN
    logic wrap_q, wrap_d;

    always_comb begin
        wrap_d = wrap_q;
        if ((sel == SEL_SEQ && seq_sum[PC_LENGTH]) || (sel == SEL_BR && br_wrap)) wrap_d = 1'b1;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) wrap_q <= 1'b0;
        else         wrap_q <= wrap_d;
    end

    assign o_wrap = wrap_q;
`endif

    assign o_pc          = pc_q;
    assign o_fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed scenarios then random traffic against a behavioural model.
module tb_pc_next_unit;

    localparam int PCW = 11;
    localparam int MOD = 2048;

    typedef struct {
        bit          rst, en, stall, halt, br, j, jr;
        logic [15:0] off;
        logic [10:0] jt, rt;
    } stim_t;

    typedef struct {
        int unsigned pc, pps, cnt, cnt3;
        bit          valid, halted, wrap;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, stall = 1'b0, halt = 1'b0, br = 1'b0, j = 1'b0, jr = 1'b0;
    logic [15:0] off = '0;
    logic [10:0] jt = '0, rt = '0;

    logic [PCW-1:0] pc_a, pps_a, pc_b, pps_b;
    logic           valid_a, halted_a, valid_b, halted_b;
    logic [31:0]    cnt_a;
    logic [2:0]     cnt_b;
`ifdef PC_WRAP_DETECT_EN
    logic           wrap_a, wrap_b;
`endif

    always #5 clk = ~clk;

    pc_next_unit dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_halt(halt),
        .i_branch_taken(br), .i_branch_offset(off), .i_jump(j), .i_jump_target(jt),
        .i_jump_reg(jr), .i_reg_target(rt), .o_pc(pc_a), .o_pc_plus_step(pps_a),
        .o_valid(valid_a), .o_halted(halted_a),
`ifdef PC_WRAP_DETECT_EN
        .o_wrap(wrap_a),
`endif
        .o_fetch_count(cnt_a)
    );

    pc_next_unit #(.COUNT_LENGTH(3)) dut3 (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_stall(stall), .i_halt(halt),
        .i_branch_taken(br), .i_branch_offset(off), .i_jump(j), .i_jump_target(jt),
        .i_jump_reg(jr), .i_reg_target(rt), .o_pc(pc_b), .o_pc_plus_step(pps_b),
        .o_valid(valid_b), .o_halted(halted_b),
`ifdef PC_WRAP_DETECT_EN
        .o_wrap(wrap_b),
`endif
        .o_fetch_count(cnt_b)
    );

    int checks = 0;
    int failures = 0;
    exp_t exp_q[$];

    // Reference model: 0 = idle, 1 = running, 2 = halted
    int          m_mode = 0;
    int unsigned m_pc = 0, m_cnt = 0;
    bit          m_wrap = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s.rst = 0; s.en = 0; s.stall = 0; s.halt = 0; s.br = 0; s.j = 0; s.jr = 0;
        s.off = '0; s.jt = '0; s.rt = '0;
        return s;
    endfunction

    function automatic void model_step(stim_t s);
        int t;
        if (s.rst) begin
            m_mode = 0; m_pc = 0; m_cnt = 0; m_wrap = 0;
        end else if (m_mode == 0) begin
            if (s.en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (s.halt) m_mode = 2;
            else if (!s.stall) begin
                m_cnt++;
                if (s.jr)      m_pc = s.rt;
                else if (s.j)  m_pc = s.jt;
                else if (s.br) begin
                    t = int'((m_pc + 1) % MOD) + int'($signed(s.off));
                    if (t < 0 || t >= MOD) m_wrap = 1;
                    m_pc = unsigned'((t + MOD) % MOD);
                end else begin
                    t = int'(m_pc) + 1;
                    if (t >= MOD) m_wrap = 1;
                    m_pc = unsigned'(t % MOD);
                end
            end
        end
    endfunction

    task automatic cyc(input stim_t s);
        exp_t e;
        @(negedge clk);
        rst = s.rst; en = s.en; stall = s.stall; halt = s.halt; br = s.br;
        j = s.j; jr = s.jr; off = s.off; jt = s.jt; rt = s.rt;
        model_step(s);
        e.pc = m_pc; e.pps = (m_pc + 1) % MOD; e.cnt = m_cnt;
        e.cnt3 = (m_cnt > 7) ? 7 : m_cnt;
        e.valid = (m_mode == 1); e.halted = (m_mode == 2); e.wrap = m_wrap;
        exp_q.push_back(e);
    endtask

    task automatic free(input int n);
        for (int i = 0; i < n; i++) cyc(nop());
    endtask

    // Monitor: every edge after a stimulus has produced an observable register update
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc",         32'(pc_a),     32'(e.pc));
                check("pc_plus",    32'(pps_a),    32'(e.pps));
                check("valid",      32'(valid_a),  32'(e.valid));
                check("halted",     32'(halted_a), 32'(e.halted));
                check("count",      cnt_a,         32'(e.cnt));
                check("count_sat3", 32'(cnt_b),    32'(e.cnt3));
                check("pc_dut3",    32'(pc_b),     32'(e.pc));
`ifdef PC_WRAP_DETECT_EN
                check("wrap",       32'(wrap_a),   32'(e.wrap));
`endif
            end
        end
    end

    initial begin
        stim_t s;
        int    r;
        s = nop(); s.rst = 1; cyc(s); cyc(s);
        s = nop(); s.en = 1; cyc(s);
        free(10);
        // Backward branch: 8 -> 9 - 3 = 6
        s = nop(); s.j = 1; s.jt = 11'd8; cyc(s);
        s = nop(); s.br = 1; s.off = 16'hFFFD; cyc(s);
        // Forward branch wrapping: 2001 + 100 -> 53
        s = nop(); s.j = 1; s.jt = 11'd2000; cyc(s);
        s = nop(); s.br = 1; s.off = 16'd100; cyc(s);
        // Stall masks jump; jump-register beats jump
        s = nop(); s.j = 1; s.jt = 11'd4; cyc(s);
        s = nop(); s.stall = 1; s.j = 1; s.jt = 11'd300; cyc(s);
        s = nop(); s.jr = 1; s.rt = 11'd77; s.j = 1; s.jt = 11'd300; cyc(s);
        // Halt beats branch, enable ignored afterwards
        s = nop(); s.j = 1; s.jt = 11'd10; cyc(s);
        s = nop(); s.halt = 1; s.br = 1; s.off = 16'd5; cyc(s);
        s = nop(); s.en = 1; cyc(s); cyc(s);
        free(2);
        // Reset mid-run wins over jump
        s = nop(); s.rst = 1; cyc(s);
        s = nop(); s.en = 1; cyc(s);
        s = nop(); s.j = 1; s.jt = 11'd42; cyc(s);
        s = nop(); s.rst = 1; s.j = 1; s.jt = 11'd99; cyc(s);
        s = nop(); s.en = 1; cyc(s);
        // Sequential wrap at the top of the address space
        s = nop(); s.j = 1; s.jt = 11'd2047; cyc(s);
        free(2);
        for (int i = 0; i < 600; i++) begin
            s = nop();
            s.rst   = ($urandom_range(0, 99) < 3);
            s.en    = ($urandom_range(0, 99) < 30);
            s.halt  = ($urandom_range(0, 99) < 2);
            s.stall = ($urandom_range(0, 99) < 25);
            s.jr    = ($urandom_range(0, 99) < 10);
            s.j     = ($urandom_range(0, 99) < 10);
            s.br    = ($urandom_range(0, 99) < 30);
            r       = int'($urandom_range(0, 1200)) - 600;
            s.off   = 16'(r);
            s.jt    = 11'($urandom);
            s.rt    = 11'($urandom);
            cyc(s);
        end
        s = nop(); s.rst = 1; cyc(s);
        s = nop(); s.en = 1; cyc(s);
        free(10);
        repeat (3) @(posedge clk);
        #3;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Registered program-counter generator for the MIPS fetch stage. Replaces the bare combinational PC + signed-offset adder with one block that owns the PC register.
- Computes PC+step, branch, jump and jump-register targets. Handles stall, halt and start-up sequencing, and counts issued fetches.
- Sits between the branch/jump resolution logic in decode and the instruction memory address port.

Parameters:
- PC_LENGTH, 11, width of PC and all address outputs.
- OFFSET_LENGTH, 16, width of signed branch offset input.
- OFFSET_SHIFT, 0, left shift applied to offset before add (0 = word-indexed instruction memory).
- INC_STEP, 1, sequential PC increment.
- RESET_PC, 0, PC value loaded on reset.
- COUNT_LENGTH, 32, width of fetch counter.

Ports:
- i_clock  in  1  system clock, all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  start fetching (IDLE -> RUN).
- i_stall  in  1  hold PC this cycle (pipeline hazard).
- i_halt  in  1  halt instruction decoded; freeze permanently.
- i_branch_taken  in  1  select branch target.
- i_branch_offset  in  OFFSET_LENGTH  signed branch offset.
- i_jump  in  1  select absolute jump target.
- i_jump_target  in  PC_LENGTH  absolute jump address.
- i_jump_reg  in  1  select register jump target.
- i_reg_target  in  PC_LENGTH  jump-register address.
- o_pc  out  PC_LENGTH  current fetch address (registered).
- o_pc_plus_step  out  PC_LENGTH  o_pc + INC_STEP (combinational from o_pc), forwarded for link/branch base.
- o_valid  out  1  o_pc is a live fetch this cycle.
- o_halted  out  1  block in HALTED.
- o_fetch_count  out  COUNT_LENGTH  number of PC advances in RUN.

Behaviour:
- Clock and reset: one clock, i_clock. Reset is synchronous and active-high on i_reset.
- Reset values: o_pc=RESET_PC, o_valid=0, o_halted=0, o_fetch_count=0, state=IDLE.
- Reset asserted mid-operation wins over every other input in the same cycle, in any state.
- FSM states:
  - IDLE: PC held, o_valid=0. Goes to RUN on the edge where i_enable=1. The PC does not advance on that edge.
  - RUN: o_valid=1. Goes to HALTED on the edge where i_halt=1. The PC is not updated on that edge, and the halt wins over stall/branch/jump.
  - HALTED: o_valid=0, o_halted=1, PC and counter frozen. Sticky until i_reset.
- Next-PC priority in RUN: i_halt > i_stall > i_jump_reg > i_jump > i_branch_taken > sequential.
- Targets:
  - Sequential: o_pc + INC_STEP.
  - Branch: o_pc_plus_step + (sign_extend(i_branch_offset) <<< OFFSET_SHIFT). The offset is sign-extended to PC_LENGTH+OFFSET_SHIFT bits before the shift.
  - Jump: i_jump_target.
  - Jump-register: i_reg_target.
- Width rules: all sums are computed one bit wider, then truncated to PC_LENGTH, i.e. wrap modulo 2^PC_LENGTH.
- Latency: the selected target appears on o_pc one cycle after the select is sampled.
- Stall: PC and counter hold. Branch/jump selects presented during a stall are ignored; decode must re-present them.
- Counter: increments by 1 on every RUN edge where the PC updates (not stalled, not halting). Saturates at all-ones, no wrap.
- Simultaneous selects: resolved strictly by the priority above. No error is flagged.

Optional Feature:
- Macro: PC_WRAP_DETECT_EN.
- Defined:
  - Adds output port o_wrap (1 bit, reset 0).
  - o_wrap is set sticky when a committed sequential or branch update wraps: carry or borrow out of the extended sum beyond PC_LENGTH bits.
  - Cleared only by i_reset.
  - Jump and jump-register targets never set it.
- Undefined: port absent; truncation behaviour identical.

Decomposition:
- Shared package pc_next_pkg holds:
  - state encoding localparams: ST_IDLE=2'b00, ST_RUN=2'b01, ST_HALTED=2'b10.
  - next-PC select encoding: SEL_HOLD, SEL_SEQ, SEL_BR, SEL_J, SEL_JR.
- One natural sub-module: pc_target_adder.
  - Parametrised PC_LENGTH/OFFSET_LENGTH/OFFSET_SHIFT.
  - Combinational unsigned-base + signed-offset adder.
  - Outputs the truncated sum and the wrap bit.
  - Instantiated for the branch target.

Test Plan:
- Reset, then i_enable=1 one cycle, then 5 free cycles -> o_pc = 0,0,1,2,3,4,5; o_valid rises on the cycle after enable; o_fetch_count=5.
- o_pc=8, i_branch_taken=1, offset=-3 (16'hFFFD) -> next o_pc=6. Offset=+100 at PC_LENGTH=11, o_pc=2000 -> o_pc=53, and o_wrap=1 when the macro is defined.
- o_pc=4 with i_stall=1, i_jump=1 and i_jump_target=300 all asserted -> o_pc stays 4, count unchanged. Then i_jump_reg=1 with i_reg_target=77 and i_jump=1 (target 300) -> o_pc=77.
- i_halt=1 together with i_branch_taken=1 at o_pc=10 -> o_pc stays 10, o_halted=1, o_valid=0. Then i_enable pulses -> state unchanged.
- i_reset asserted mid-RUN at o_pc=42 with i_jump=1 -> next cycle o_pc=RESET_PC, o_valid=0, count=0, state IDLE.
- COUNT_LENGTH=3 with 10 free RUN cycles -> o_fetch_count saturates at 7.
